// File: rtl/sp_core.sv
// sp_core: single-issue 3-stage (IF / EX / WB) core with full WB->EX forwarding and no stalls.
// Optional macro SP_ADDR_CHECK_EN adds a sticky addr_err output for out-of-range lw/sw addresses.
module sp_core #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              out_valid,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef SP_ADDR_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  logic [DATA_W-1:0] r [0:31];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ex_v_q, ex_v_d;
  logic              wb_v_q, wb_v_d;
  logic              wb_we_q, wb_we_d;
  logic              wb_ld_q, wb_ld_d;
  logic [4:0]        wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
  logic              out_valid_q, out_valid_d;

  logic [5:0]        op, func;
  logic [4:0]        rs, rt, rd, shamt;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_s, imm_z;
  logic [DATA_W-1:0] wb_val, op_a, op_b, alu;
  logic [ADDR_W-1:0] ea_lo;
  logic              dec_we, dec_ld, dec_st;
  logic [4:0]        dec_dest;

  assign op    = inst_rdata[31:26];
  assign rs    = inst_rdata[25:21];
  assign rt    = inst_rdata[20:16];
  assign rd    = inst_rdata[15:11];
  assign shamt = inst_rdata[10:6];
  assign func  = inst_rdata[5:0];
  assign imm   = inst_rdata[15:0];
  assign imm_s = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_z = {{(DATA_W-16){1'b0}}, imm};

  // The WB value (ALU result or returning load data) bypasses the register file.
  assign wb_val = wb_ld_q ? mem_rdata : wb_alu_q;
  assign op_a   = (wb_v_q && wb_we_q && (wb_dest_q == rs)) ? wb_val : r[rs];
  assign op_b   = (wb_v_q && wb_we_q && (wb_dest_q == rt)) ? wb_val : r[rt];
  assign ea_lo  = op_a[ADDR_W-1:0] + imm_s[ADDR_W-1:0];

  always_comb begin
    dec_we   = 1'b0;
    dec_ld   = 1'b0;
    dec_st   = 1'b0;
    dec_dest = rt;
    alu      = '0;
    case (op)
      6'd0: begin
        dec_dest = rd;
        dec_we   = 1'b1;
        case (func)
          6'd0:    alu = op_a & op_b;
          6'd1:    alu = op_a | op_b;
          6'd2:    alu = op_a + op_b;
          6'd3:    alu = op_a - op_b;
          6'd4:    alu = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          6'd5:    alu = op_a << shamt;
          6'd6:    alu = ~(op_a | op_b);
          default: dec_we = 1'b0;
        endcase
      end
      6'd1: begin alu = op_a & imm_z; dec_we = 1'b1; end
      6'd2: begin alu = op_a | imm_z; dec_we = 1'b1; end
      6'd3: begin alu = op_a + imm_s; dec_we = 1'b1; end
      6'd4: begin alu = op_a - imm_s; dec_we = 1'b1; end
      6'd5: begin dec_ld = 1'b1; dec_we = 1'b1; end
      6'd6: dec_st = 1'b1;
      6'd9: begin alu = {imm, {(DATA_W-16){1'b0}}}; dec_we = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    pc_d        = in_valid ? pc_q + ADDR_W'(1) : pc_q;
    ex_v_d      = in_valid;
    wb_v_d      = ex_v_q;
    wb_we_d     = ex_v_q & dec_we;
    wb_ld_d     = ex_v_q & dec_ld;
    wb_dest_d   = dec_dest;
    wb_alu_d    = alu;
    out_valid_d = wb_v_q;
  end

  // Store strobe is suppressed during reset so a flushed sw never lands.
  assign inst_addr = pc_q;
  assign out_valid = out_valid_q;
  assign mem_wen   = ex_v_q & dec_st & ~rst;
  assign mem_addr  = (ex_v_q & (dec_ld | dec_st)) ? ea_lo : '0;
  assign mem_wdata = (ex_v_q & dec_st) ? op_b : '0;

`ifdef SP_ADDR_CHECK_EN
  logic              addr_err_q, addr_err_d;
  logic [DATA_W-1:0] ea_full;
  assign ea_full = op_a + imm_s;
  // Any set bit above the word range means negative or >= 2^ADDR_W.
  assign addr_err_d = addr_err_q | (ex_v_q & (dec_ld | dec_st) & (|ea_full[DATA_W-1:ADDR_W]));
  assign addr_err   = addr_err_q;

  always_ff @(posedge clk) begin
    if (rst) addr_err_q <= 1'b0;
    else     addr_err_q <= addr_err_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      ex_v_q      <= 1'b0;
      wb_v_q      <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_ld_q     <= 1'b0;
      wb_dest_q   <= '0;
      wb_alu_q    <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 32; i++) r[i] <= '0;
    end else begin
      pc_q        <= pc_d;
      ex_v_q      <= ex_v_d;
      wb_v_q      <= wb_v_d;
      wb_we_q     <= wb_we_d;
      wb_ld_q     <= wb_ld_d;
      wb_dest_q   <= wb_dest_d;
      wb_alu_q    <= wb_alu_d;
      out_valid_q <= out_valid_d;
      if (wb_v_q && wb_we_q) r[wb_dest_q] <= wb_val;
    end
  end

endmodule

// File: tb/tb_sp_core.sv
// Bench for sp_core: ISA-level reference model feeds a scoreboard of register-file snapshots,
// checked by a monitor on every retirement, plus directed value, latency and reset checks.
module tb_sp_core;
  localparam int ADDR_W = 12;
  localparam int W      = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_valid;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_rdata;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
`ifdef SP_ADDR_CHECK_EN
  logic              addr_err;
`endif

  sp_core #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .out_valid(out_valid),
    .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef SP_ADDR_CHECK_EN
    , .addr_err(addr_err)
`endif
  );

  // ---------------- clock / reset / memories ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rom  [4096];
  logic [31:0] dmem [4096];

  function automatic logic [31:0] init_word(input int i);
    return (i == 10) ? 32'h0000_1234 : ((32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F);
  endfunction

  always @(posedge clk) inst_rdata <= rom[inst_addr];

  initial begin
    for (int i = 0; i < 4096; i++) dmem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_wen) dmem[mem_addr] <= mem_wdata;
      mem_rdata <= dmem[mem_addr];
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] m_r [32];
  logic [31:0] m_mem [4096];
  logic [11:0] m_pc;
  logic        m_err;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_r[i] = '0;
    m_pc  = '0;
    m_err = 1'b0;
  endtask

  task automatic model_exec(input logic [31:0] ins);
    logic [31:0] a, b, sx, zx, ea;
    logic [4:0]  rt, rd;
    a  = m_r[ins[25:21]];
    b  = m_r[ins[20:16]];
    rt = ins[20:16];
    rd = ins[15:11];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    ea = a + sx;
    case (ins[31:26])
      6'd0: case (ins[5:0])
        6'd0: m_r[rd] = a & b;
        6'd1: m_r[rd] = a | b;
        6'd2: m_r[rd] = a + b;
        6'd3: m_r[rd] = a - b;
        6'd4: m_r[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'd5: m_r[rd] = a << ins[10:6];
        6'd6: m_r[rd] = ~(a | b);
        default: ;
      endcase
      6'd1: m_r[rt] = a & zx;
      6'd2: m_r[rt] = a | zx;
      6'd3: m_r[rt] = a + sx;
      6'd4: m_r[rt] = a - sx;
      6'd5: begin m_err = m_err | (ea >= 32'd4096); m_r[rt] = m_mem[ea[11:0]]; end
      6'd6: begin m_err = m_err | (ea >= 32'd4096); m_mem[ea[11:0]] = b; end
      6'd9: m_r[rt] = {ins[15:0], 16'h0};
      default: ;
    endcase
  endtask

  function automatic logic [W-1:0] pack_model();
    logic [W-1:0] p;
    for (int i = 0; i < 32; i++) p[i*32 +: 32] = m_r[i];
    return p;
  endfunction

  function automatic logic [W-1:0] dut_regs();
    logic [W-1:0] p;
    for (int i = 0; i < 32; i++) p[i*32 +: 32] = dut.r[i];
    return p;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  int           ret_log[$];
  int           cmp_cnt = 0;
  int           fail_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      for (int i = 0; i < 32; i++)
        if (act[i*32 +: 32] !== exp[i*32 +: 32]) begin
          $display("FAIL %s: r[%0d] got %h expected %h (cycle %0d)", name, i,
                   act[i*32 +: 32], exp[i*32 +: 32], cyc);
          break;
        end
    end
  endtask

  // Monitor: every out_valid pulse pops one expected snapshot and its issue cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ret_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          cmp_cnt++;
          fail_cnt++;
          $display("FAIL retire: out_valid at cycle %0d with nothing in flight", cyc);
        end else begin
          chk_regs("retire_regs", dut_regs(), exp_q.pop_front());
          chk("retire_latency", cyc, cyc_q.pop_front() + 2);
        end
      end
      if (rst) begin
        exp_q.delete();
        cyc_q.delete();
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] rand_inst(input bit mem_ok);
    int          sel = $urandom_range(0, 15);
    int          rs  = $urandom_range(0, 7);
    int          rt  = $urandom_range(0, 7);
    int          rd  = $urandom_range(0, 7);
    int          sh  = $urandom_range(0, 31);
    logic [15:0] imm = 16'($urandom);
    if (sel <= 6) return enc_r(rs, rt, rd, sh, sel);
    case (sel)
      7:       return enc_r(rs, rt, rd, sh, $urandom_range(7, 63));
      8:       return enc_i(1, rs, rt, imm);
      9:       return enc_i(2, rs, rt, imm);
      10:      return enc_i(3, rs, rt, imm);
      11:      return enc_i(4, rs, rt, imm);
      12:      return enc_i(9, rs, rt, imm);
      13:      return enc_i(($urandom_range(0, 1) != 0) ? 7 : $urandom_range(10, 63), rs, rt, imm);
      14:      return enc_i(mem_ok ? 5 : 3, rs, rt, imm);
      default: return enc_i(mem_ok ? 6 : 4, rs, rt, imm);
    endcase
  endfunction

  task automatic model_issue();
    model_exec(rom[m_pc]);
    m_pc = m_pc + 12'd1;
    exp_q.push_back(pack_model());
    cyc_q.push_back(cyc + 1);
  endtask

  task automatic issue_slot(input bit v);
    @(posedge clk);
    #1;
    in_valid = v;
    if (v) model_issue();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk_regs({name, "_regs"}, dut_regs(), '0);
`ifdef SP_ADDR_CHECK_EN
    chk({name, "_addr_err"}, 32'(addr_err), 32'd0);
`endif
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 40) begin
      @(posedge clk);
      g++;
    end
    @(negedge clk);
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 4096; i++) if (dmem[i] !== m_mem[i]) bad++;
    chk(name, bad, 0);
  endtask

  // ---------------- main sequence ----------------
  int base;
  int e0;
  int g;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      m_mem[i] = init_word(i);
      rom[i]   = '0;
    end
    model_reset();

    do_reset();
    check_reset_state("reset");

    // Directed program: ALU ops, load-use, store-then-load, lui/nor/unknown, high address.
    rom[0]  = enc_i(3, 0, 1, 16'hFFFB);
    rom[1]  = enc_i(2, 1, 2, 16'h8000);
    rom[2]  = enc_r(1, 0, 3, 0, 4);
    rom[3]  = enc_r(1, 0, 4, 4, 5);
    rom[4]  = enc_i(5, 0, 5, 16'd10);
    rom[5]  = enc_r(5, 5, 6, 0, 2);
    rom[6]  = enc_i(3, 0, 7, 16'd77);
    rom[7]  = enc_i(6, 0, 7, 16'd100);
    rom[8]  = enc_i(5, 0, 8, 16'd100);
    rom[9]  = enc_i(9, 0, 9, 16'hABCD);
    rom[10] = enc_r(0, 0, 10, 0, 6);
    rom[11] = enc_i(7, 1, 2, 16'h1234);
    rom[12] = enc_i(5, 0, 11, 16'h1000);
    do_reset();
    base = ret_log.size();
    for (int i = 0; i < 13; i++) issue_slot(1'b1);
    issue_slot(1'b0);
    drain();
    chk("dir_retired", ret_log.size() - base, 13);
    chk("dir_addi_r1", dut.r[1], 32'hFFFF_FFFB);
    chk("dir_ori_r2", dut.r[2], 32'hFFFF_FFFB);
    chk("dir_slt_r3", dut.r[3], 32'h0000_0001);
    chk("dir_sll_r4", dut.r[4], 32'hFFFF_FFB0);
    chk("dir_lw_r5", dut.r[5], 32'h0000_1234);
    chk("dir_loaduse_r6", dut.r[6], 32'h0000_2468);
    chk("dir_addi_r7", dut.r[7], 32'd77);
    chk("dir_swlw_r8", dut.r[8], 32'd77);
    chk("dir_lui_r9", dut.r[9], 32'hABCD_0000);
    chk("dir_nor_r10", dut.r[10], 32'hFFFF_FFFF);
    chk("dir_mem100", dmem[100], 32'd77);
    check_mem("dir_dmem");
`ifdef SP_ADDR_CHECK_EN
    chk("dir_addr_err", 32'(addr_err), 32'd1);
`endif

    // Latency and drain: 20 consecutive slots retire over exactly 20 consecutive cycles.
    for (int i = 0; i < 64; i++) rom[i] = rand_inst(1'b1);
    do_reset();
    base = ret_log.size();
    e0 = 0;
    for (int i = 0; i < 20; i++) begin
      issue_slot(1'b1);
      if (i == 0) e0 = cyc + 1;
    end
    issue_slot(1'b0);
    drain();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lat_count", ret_log.size() - base, 20);
    if (ret_log.size() >= base + 20) begin
      chk("lat_first", ret_log[base], e0 + 2);
      chk("lat_last", ret_log[base + 19], e0 + 21);
    end
    check_mem("lat_dmem");

    // Random program with random slot gaps.
    for (int i = 0; i < 1024; i++) rom[i] = rand_inst(1'b1);
    do_reset();
    for (int i = 0; i < 400; i++) issue_slot($urandom_range(0, 99) < 70);
    issue_slot(1'b0);
    drain();
    check_mem("rand_dmem");
`ifdef SP_ADDR_CHECK_EN
    chk("rand_addr_err", 32'(addr_err), 32'(m_err));
`endif

    // Reset mid-stream after 5 retirements; in-flight work must vanish.
    for (int i = 0; i < 64; i++) rom[i] = rand_inst(1'b0);
    rom[0] = enc_i(3, 0, 1, 16'h0123);
    do_reset();
    base = ret_log.size();
    g = 0;
    while (ret_log.size() - base < 5 && g < 50) begin
      issue_slot(1'b1);
      g++;
    end
    chk("mid_five_retired", 32'((ret_log.size() - base) >= 5), 32'd1);
    do_reset();
    check_reset_state("mid_reset");
    base = ret_log.size();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mid_no_retire", ret_log.size() - base, 0);
    for (int i = 0; i < 12; i++) issue_slot(1'b1);
    issue_slot(1'b0);
    drain();
    chk("mid_restart_count", ret_log.size() - base, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
